// File: rtl/serv_mtimer_pkg.sv
// Shared constants for the serv machine timer: register word map and timer width.
// Width follows SERV_MTIMER_64BIT_EN (64-bit mtime/mtimecmp when defined, 32-bit otherwise).
package serv_mtimer_pkg;

  localparam logic [1:0] MTIME_LO    = 2'd0;
  localparam logic [1:0] MTIME_HI    = 2'd1;
  localparam logic [1:0] MTIMECMP_LO = 2'd2;
  localparam logic [1:0] MTIMECMP_HI = 2'd3;

`ifdef SERV_MTIMER_64BIT_EN
  localparam int unsigned MT_W = 64;
`else
  localparam int unsigned MT_W = 32;
`endif

  localparam logic [MT_W-1:0] MT_ONE       = {{(MT_W-1){1'b0}}, 1'b1};
  localparam logic [MT_W-1:0] MTIMECMP_RST = {MT_W{1'b1}};

  function automatic logic [31:0] word_of(input logic [MT_W-1:0] v, input logic hi);
`ifdef SERV_MTIMER_64BIT_EN
    return hi ? v[63:32] : v[31:0];
`else
    return hi ? 32'd0 : v[31:0];
`endif
  endfunction

  // Replace one 32-bit half, leaving the other half untouched.
  function automatic logic [MT_W-1:0] word_put(input logic [MT_W-1:0] v, input logic hi,
                                               input logic [31:0] dat);
`ifdef SERV_MTIMER_64BIT_EN
    return hi ? {dat, v[31:0]} : {v[63:32], dat};
`else
    return hi ? v : dat;
`endif
  endfunction

endpackage

// File: rtl/serv_mtimer_presc.sv
// Prescaler for the machine timer: counts 0..DIV-1 and flags a tick on the last count.
// A synchronous clear restarts the count from 0.
module serv_mtimer_presc #(
  parameter int DIV   = 1,
  parameter int DIV_W = 16
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic clr,
  output logic tick
);

  localparam logic [DIV_W-1:0] LAST = DIV_W'(DIV - 1);
  localparam logic [DIV_W-1:0] ONE  = {{(DIV_W-1){1'b0}}, 1'b1};

  logic [DIV_W-1:0] cnt_r;
  logic             tick_s;

  // Tick decode from the current count.
  always_comb begin
    tick_s = (cnt_r == LAST);
  end

  // Prescaler counter with clear and wrap.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_r <= {DIV_W{1'b0}};
    end else if (clr || tick_s) begin
      cnt_r <= {DIV_W{1'b0}};
    end else begin
      cnt_r <= cnt_r + ONE;
    end
  end

  assign tick = tick_s;

endmodule

// File: rtl/serv_mtimer.sv
// serv machine timer: mtime/mtimecmp behind a Wishbone classic slave, registered o_mtip.
// Define SERV_MTIMER_64BIT_EN for 64-bit registers (words 1 and 3 mapped).
module serv_mtimer
  import serv_mtimer_pkg::*;
#(
  parameter int DIV   = 1,
  parameter int DIV_W = 16
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_wb_cyc,
  input  logic        i_wb_we,
  input  logic [1:0]  i_wb_adr,
  input  logic [31:0] i_wb_dat,
  output logic [31:0] o_wb_dat,
  output logic        o_wb_ack,
  output logic        o_mtip
);

  logic [MT_W-1:0] mtime_r;
  logic [MT_W-1:0] mtimecmp_r;
  logic [MT_W-1:0] mtime_nxt_s;
  logic [MT_W-1:0] mtimecmp_nxt_s;
  logic            ack_r;
  logic [31:0]     dat_r;
  logic            mtip_r;
  logic            access_s;
  logic            wr_s;
  logic            mtime_wr_s;
  logic            tick_s;
  logic [31:0]     rdata_s;

  serv_mtimer_presc #(
    .DIV   (DIV),
    .DIV_W (DIV_W)
  ) u_presc (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .clr     (mtime_wr_s),
    .tick    (tick_s)
  );

  // Bus decode, read mux and next-state for mtime/mtimecmp; an mtime write overrides the tick.
  always_comb begin
    access_s       = i_wb_cyc & ~ack_r;
    wr_s           = access_s & i_wb_we;
    mtime_wr_s     = 1'b0;
    rdata_s        = 32'd0;
    mtimecmp_nxt_s = mtimecmp_r;
    mtime_nxt_s    = tick_s ? (mtime_r + MT_ONE) : mtime_r;
    case (i_wb_adr)
      MTIME_LO: begin
        rdata_s = word_of(mtime_r, 1'b0);
        if (wr_s) begin
          mtime_wr_s  = 1'b1;
          mtime_nxt_s = word_put(mtime_r, 1'b0, i_wb_dat);
        end else begin
          mtime_wr_s  = 1'b0;
        end
      end
      MTIMECMP_LO: begin
        rdata_s = word_of(mtimecmp_r, 1'b0);
        if (wr_s) begin
          mtimecmp_nxt_s = word_put(mtimecmp_r, 1'b0, i_wb_dat);
        end else begin
          mtimecmp_nxt_s = mtimecmp_r;
        end
      end
`ifdef SERV_MTIMER_64BIT_EN
      MTIME_HI: begin
        rdata_s = word_of(mtime_r, 1'b1);
        if (wr_s) begin
          mtime_wr_s  = 1'b1;
          mtime_nxt_s = word_put(mtime_r, 1'b1, i_wb_dat);
        end else begin
          mtime_wr_s  = 1'b0;
        end
      end
      MTIMECMP_HI: begin
        rdata_s = word_of(mtimecmp_r, 1'b1);
        if (wr_s) begin
          mtimecmp_nxt_s = word_put(mtimecmp_r, 1'b1, i_wb_dat);
        end else begin
          mtimecmp_nxt_s = mtimecmp_r;
        end
      end
`endif
      default: begin
        rdata_s = 32'd0;
      end
    endcase
  end

  // State registers, single-cycle ack with read data, and registered compare.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      mtime_r    <= {MT_W{1'b0}};
      mtimecmp_r <= MTIMECMP_RST;
      ack_r      <= 1'b0;
      dat_r      <= 32'd0;
      mtip_r     <= 1'b0;
    end else begin
      mtime_r    <= mtime_nxt_s;
      mtimecmp_r <= mtimecmp_nxt_s;
      ack_r      <= access_s;
      dat_r      <= (access_s && !i_wb_we) ? rdata_s : 32'd0;
      mtip_r     <= (mtime_r >= mtimecmp_r);
    end
  end

  assign o_wb_dat = dat_r;
  assign o_wb_ack = ack_r;
  assign o_mtip   = mtip_r;

endmodule

// File: tb/tb_serv_mtimer.sv
// Directed testbench for serv_mtimer: one DIV=1 instance and one DIV=4 instance.
module tb_serv_mtimer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cyc0, cyc1, we;
  logic [1:0]  adr;
  logic [31:0] wdat;
  logic [31:0] dat0, dat1;
  logic        ack0, ack1, mtip0, mtip1;

  int errors = 0;
  int checks = 0;

  logic [31:0] rd;
  logic        a_hit, a_after;

  always #5 clk = ~clk;

  serv_mtimer #(.DIV(1), .DIV_W(16)) dut0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_wb_cyc(cyc0), .i_wb_we(we), .i_wb_adr(adr),
    .i_wb_dat(wdat), .o_wb_dat(dat0), .o_wb_ack(ack0), .o_mtip(mtip0)
  );

  serv_mtimer #(.DIV(4), .DIV_W(16)) dut4 (
    .i_clk(clk), .i_rst_n(rst_n), .i_wb_cyc(cyc1), .i_wb_we(we), .i_wb_adr(adr),
    .i_wb_dat(wdat), .o_wb_dat(dat1), .o_wb_ack(ack1), .o_mtip(mtip1)
  );

  // One bus access: drive at negedge, access on next posedge, ack seen just after it.
  task automatic bus(input int d, input logic w, input logic [1:0] a, input logic [31:0] v,
                     output logic [31:0] r, output logic hit, output logic after);
    @(negedge clk);
    we = w; adr = a; wdat = v;
    if (d == 0) cyc0 = 1'b1; else cyc1 = 1'b1;
    @(posedge clk); #1;
    hit = (d == 0) ? ack0 : ack1;
    r   = (d == 0) ? dat0 : dat1;
    cyc0 = 1'b0; cyc1 = 1'b0;
    @(posedge clk); #1;
    after = (d == 0) ? ack0 : ack1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; cyc0 = 1'b0; cyc1 = 1'b0; we = 1'b0; adr = 2'd0; wdat = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({ack0, mtip0, dat0} !== 34'd0) begin
      errors++; $display("FAIL reset_dut0: ack=%0b mtip=%0b dat=%h, want 0", ack0, mtip0, dat0);
    end
    checks++;
    if ({ack1, mtip1, dat1} !== 34'd0) begin
      errors++; $display("FAIL reset_dut4: ack=%0b mtip=%0b dat=%h, want 0", ack1, mtip1, dat1);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_free_run();
    // mtime is 9 after the 9th edge; the read samples it on the 10th edge.
    for (int i = 0; i < 9; i++) begin
      @(posedge clk); #1;
      checks++;
      if (mtip0 !== 1'b0) begin
        errors++; $display("FAIL free_run_mtip cycle %0d: got %0b want 0", i, mtip0);
      end
    end
    bus(0, 1'b0, 2'd0, 32'd0, rd, a_hit, a_after);
    checks++;
    if (rd !== 32'd9) begin
      errors++; $display("FAIL free_run_mtime: got %0d want 9", rd);
    end
    checks++;
    if (a_hit !== 1'b1 || a_after !== 1'b0) begin
      errors++; $display("FAIL ack_pulse: got %0b%0b want 10", a_hit, a_after);
    end
    checks++;
    if (dat0 !== 32'd0) begin
      errors++; $display("FAIL dat_idle: got %h want 0", dat0);
    end
  endtask

  task automatic test_compare();
    bus(0, 1'b1, 2'd2, 32'd20, rd, a_hit, a_after);
    bus(0, 1'b1, 2'd0, 32'd0, rd, a_hit, a_after);
    // Now one edge after the mtime write: mtime=1. mtime hits 20 after 19 more edges.
    repeat (19) @(posedge clk);
    #1;
    checks++;
    if (mtip0 !== 1'b0) begin
      errors++; $display("FAIL mtip_early: got %0b want 0", mtip0);
    end
    @(posedge clk); #1;
    checks++;
    if (mtip0 !== 1'b1) begin
      errors++; $display("FAIL mtip_rise: got %0b want 1", mtip0);
    end
    bus(0, 1'b1, 2'd2, 32'd100, rd, a_hit, a_after);
    checks++;
    if (mtip0 !== 1'b0) begin
      errors++; $display("FAIL mtip_fall: got %0b want 0", mtip0);
    end
    bus(0, 1'b0, 2'd2, 32'd0, rd, a_hit, a_after);
    checks++;
    if (rd !== 32'd100) begin
      errors++; $display("FAIL cmp_readback: got %0d want 100", rd);
    end
  endtask

  task automatic test_div4();
    bus(1, 1'b1, 2'd0, 32'd0, rd, a_hit, a_after);
    // Ticks land on the 4th, 8th, ... edges after the write; read after the 16th.
    repeat (15) @(posedge clk);
    bus(1, 1'b0, 2'd0, 32'd0, rd, a_hit, a_after);
    checks++;
    if (rd !== 32'd4) begin
      errors++; $display("FAIL div4_count: got %0d want 4", rd);
    end
    // Align the next write with the 20th edge, which is a tick edge.
    @(posedge clk);
    bus(1, 1'b1, 2'd0, 32'd7, rd, a_hit, a_after);
    bus(1, 1'b0, 2'd0, 32'd0, rd, a_hit, a_after);
    checks++;
    if (rd !== 32'd7) begin
      errors++; $display("FAIL div4_write_wins: got %0d want 7", rd);
    end
    checks++;
    if (mtip1 !== 1'b0) begin
      errors++; $display("FAIL div4_mtip: got %0b want 0", mtip1);
    end
  endtask

`ifdef SERV_MTIMER_64BIT_EN
  task automatic test_wide();
    bus(0, 1'b1, 2'd1, 32'd0, rd, a_hit, a_after);
    bus(0, 1'b1, 2'd3, 32'd1, rd, a_hit, a_after);
    bus(0, 1'b1, 2'd2, 32'd0, rd, a_hit, a_after);
    bus(0, 1'b1, 2'd0, 32'hFFFF_FFFF, rd, a_hit, a_after);
    checks++;
    if (mtip0 !== 1'b0) begin
      errors++; $display("FAIL wide_mtip_before: got %0b want 0", mtip0);
    end
    @(posedge clk); #1;
    checks++;
    if (mtip0 !== 1'b1) begin
      errors++; $display("FAIL wide_mtip_carry: got %0b want 1", mtip0);
    end
    bus(0, 1'b0, 2'd1, 32'd0, rd, a_hit, a_after);
    checks++;
    if (rd !== 32'd1) begin
      errors++; $display("FAIL wide_hi: got %h want 1", rd);
    end
    bus(0, 1'b0, 2'd3, 32'd0, rd, a_hit, a_after);
    checks++;
    if (rd !== 32'd1) begin
      errors++; $display("FAIL wide_cmp_hi: got %h want 1", rd);
    end
  endtask
`else
  task automatic test_wrap32();
    bus(0, 1'b1, 2'd2, 32'hFFFF_FFFF, rd, a_hit, a_after);
    bus(0, 1'b1, 2'd0, 32'hFFFF_FFFE, rd, a_hit, a_after);
    checks++;
    if (mtip0 !== 1'b0) begin
      errors++; $display("FAIL wrap_mtip_pre: got %0b want 0", mtip0);
    end
    @(posedge clk); #1;
    checks++;
    if (mtip0 !== 1'b1) begin
      errors++; $display("FAIL wrap_mtip_hit: got %0b want 1", mtip0);
    end
    @(posedge clk); #1;
    checks++;
    if (mtip0 !== 1'b0) begin
      errors++; $display("FAIL wrap_mtip_post: got %0b want 0", mtip0);
    end
    bus(0, 1'b1, 2'd1, 32'h1234_5678, rd, a_hit, a_after);
    checks++;
    if (a_hit !== 1'b1) begin
      errors++; $display("FAIL unmapped_write_ack: got %0b want 1", a_hit);
    end
    bus(0, 1'b0, 2'd1, 32'd0, rd, a_hit, a_after);
    checks++;
    if (rd !== 32'd0) begin
      errors++; $display("FAIL word1_read: got %h want 0", rd);
    end
    bus(0, 1'b0, 2'd3, 32'd0, rd, a_hit, a_after);
    checks++;
    if (rd !== 32'd0) begin
      errors++; $display("FAIL word3_read: got %h want 0", rd);
    end
  endtask
`endif

  task automatic test_reset_mid_access();
    bus(0, 1'b1, 2'd2, 32'd0, rd, a_hit, a_after);
    checks++;
    if (mtip0 !== 1'b1) begin
      errors++; $display("FAIL mid_mtip_set: got %0b want 1", mtip0);
    end
    @(negedge clk);
    we = 1'b0; adr = 2'd0; cyc0 = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (ack0 !== 1'b1 || dat0 === 32'd0) begin
      errors++; $display("FAIL mid_ack_pending: ack=%0b dat=%h, want ack 1 dat nonzero", ack0, dat0);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({ack0, mtip0, dat0} !== 34'd0) begin
      errors++; $display("FAIL mid_async_clear: ack=%0b mtip=%0b dat=%h, want 0", ack0, mtip0, dat0);
    end
    cyc0 = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    bus(0, 1'b0, 2'd0, 32'd0, rd, a_hit, a_after);
    checks++;
    if (rd !== 32'd1) begin
      errors++; $display("FAIL mid_mtime_reset: got %0d want 1", rd);
    end
    bus(0, 1'b0, 2'd2, 32'd0, rd, a_hit, a_after);
    checks++;
    if (rd !== 32'hFFFF_FFFF) begin
      errors++; $display("FAIL mid_cmp_reset: got %h want ffffffff", rd);
    end
    checks++;
    if (mtip0 !== 1'b0) begin
      errors++; $display("FAIL mid_mtip_after: got %0b want 0", mtip0);
    end
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_compare();
    test_div4();
`ifdef SERV_MTIMER_64BIT_EN
    test_wide();
`else
    test_wrap32();
`endif
    test_reset_mid_access();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/serv_mtimer.md
Name: serv_mtimer

Overview:
- Machine-timer peripheral generating the timer interrupt request consumed as i_mtip by the CSR stage.
- Holds a free-running mtime counter and an mtimecmp compare register, both accessible over a Wishbone classic slave port.
- o_mtip is registered and level-sensitive. The CSR stage does its own edge detection and enable masking.

Parameters:
- DIV, 1: mtime increments once every DIV clocks. Legal range 1..65535.
- DIV_W, 16: width of the prescaler counter. Must satisfy 2^DIV_W > DIV.

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  reset, asynchronous, active-low
- i_wb_cyc  in  1  bus cycle valid; cyc and stb are combined externally
- i_wb_we  in  1  write enable
- i_wb_adr  in  2  word address; adr[1:0] = {reg, half}
- i_wb_dat  in  32  write data
- o_wb_dat  out  32  read data, valid while o_wb_ack=1
- o_wb_ack  out  1  single-cycle acknowledge
- o_mtip  out  1  timer interrupt pending, to the CSR stage i_mtip

Behaviour:
- Reset (i_rst_n low, async; release is synchronous to i_clk):
  - mtime = 0, mtimecmp = all ones, prescaler = 0
  - o_mtip = 0, o_wb_ack = 0, o_wb_dat = 0
- Address map, word index:
  - 0: mtime[31:0]
  - 1: mtime[63:32] (feature only)
  - 2: mtimecmp[31:0]
  - 3: mtimecmp[63:32] (feature only)
- Prescaler:
  - Counts 0..DIV-1; tick asserted in the cycle prescaler == DIV-1, then prescaler wraps to 0.
  - DIV=1: tick every cycle.
- mtime:
  - Increments on tick and wraps modulo 2^W (W=32, or 64 with the feature).
  - Carry from low to high word occurs in the same cycle.
- Bus handshake:
  - i_wb_cyc=1 and o_wb_ack=0 → access performed, o_wb_ack=1 next cycle for exactly 1 cycle.
  - i_wb_cyc is ignored while o_wb_ack=1, so back-to-back accesses give ack every other cycle at most.
  - Master must hold cyc/adr/we/dat until ack.
- Write:
  - Takes effect in the access cycle; the new value is visible from the next cycle.
  - Full 32-bit words only; no byte selects.
  - Write to mtime word resets the prescaler to 0.
  - Write to mtime in a tick cycle: the write wins and no increment occurs.
  - 64-bit: write to one half leaves the other half unchanged; low-word write suppresses that cycle's carry into the high word.
- Read:
  - o_wb_dat registered with ack, holding the value sampled in the access cycle (pre-tick).
  - o_wb_dat returns to 0 when ack is low.
  - Unmapped words read 0; writes to them are ignored but still acked.
- Interrupt:
  - o_mtip <= (mtime >= mtimecmp), unsigned compare, registered.
  - Latency: 1 cycle after the mtime/mtimecmp update.
  - Stays high until mtimecmp is raised above mtime or mtime is rewritten below it.
  - Wrap of mtime past all-ones deasserts o_mtip (unsigned semantics).
- Reset mid-access: ack is dropped immediately; the pending access is lost.

Optional Feature:
- Macro: SERV_MTIMER_64BIT_EN
- Defined: mtime and mtimecmp are 64 bits; words 1 and 3 are mapped; the compare uses the full 64 bits; mtimecmp resets to 64'hFFFF_FFFF_FFFF_FFFF.
- Undefined: 32-bit registers only; words 1 and 3 read 0 and ignore writes.

Decomposition:
- Shared params header (alongside the existing CSR source constants): register word indices MTIME_LO=0, MTIME_HI=1, MTIMECMP_LO=2, MTIMECMP_HI=3.
- One natural sub-module, serv_mtimer_presc: the prescaler counter with synchronous clear, producing the tick.
- All remaining logic stays in serv_mtimer.

Test Plan:
- Reset released, DIV=1, no bus traffic → o_mtip=0 forever; mtime read after 10 cycles = 10±1 (fixed by sample point); ack exactly 1 cycle.
- Write mtimecmp=20, mtime=0 → o_mtip rises exactly 1 cycle after mtime reaches 20; then write mtimecmp=100 → o_mtip falls next cycle.
- DIV=4: write mtime=0, wait 16 cycles → mtime=4; write mtime during a tick cycle with value 7 → read returns 7, not 8.
- 32-bit build, write mtime=FFFF_FFFE, mtimecmp=FFFF_FFFF → o_mtip asserts, then deasserts after wrap to 0; read word 1 → 0.
- 64-bit build, write mtime lo=FFFF_FFFF, hi=0 → after 1 tick, hi=1 and lo=0; compare against mtimecmp={1,0} asserts o_mtip.
- Assert i_rst_n low while ack pending → ack, o_mtip and o_wb_dat go 0 without a clock edge; registers return to reset values.
